retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//   Synthesizable retirement-trace recorder for the cpu core. Classifies each retired
//   instruction (reg write, load, store, halt, nop/branch) and tags it with an instruction number.
//   Buffers the tagged records in a FWFT FIFO drained by a valid/ready consumer.
//   Keeps cycle/instruction counters, halt and watchdog-timeout status; replaces per-cycle
//   sampling with an explicit retire strobe so pipelined cores trace correctly.
// PARAMETERS
//   DATA_W   16      width of pc, inst, reg/mem data and mem address
//   REG_W    4       register index width
//   DEPTH    16      FIFO entries; power of two, >=2
//   CNT_W    32      width of cycle/inst/drop counters and record inst number
//   TIMEOUT  100000  watchdog limit in cycles; 0 disables watchdog
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       synchronous clear of counters, flags and FIFO
//   ret_valid  in   1       one instruction retires this cycle
//   ret_pc     in   DATA_W  pc of retiring instruction
//   ret_inst   in   DATA_W  instruction word
//   reg_we     in   1       register write; reg_dst/reg_data valid
//   reg_dst    in   REG_W   destination register
//   reg_data   in   DATA_W  write-back data
//   mem_rd     in   1       memory read (load)
//   mem_wr     in   1       memory write (store)
//   mem_addr   in   DATA_W  memory address
//   mem_data   in   DATA_W  store data
//   hlt        in   1       retiring instruction is halt
//   out_valid  out  1       head record available
//   out_ready  in   1       consumer accepts head record
//   out_kind   out  3       0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 HALT
//   out_inum   out  CNT_W   instruction number (0-based)
//   out_pc     out  DATA_W  pc
//   out_reg    out  REG_W   dst register (REG/LOAD), else 0
//   out_addr   out  DATA_W  mem address (LOAD/STORE), else 0
//   out_value  out  DATA_W  reg_data (REG/LOAD), mem_data (STORE), else 0
//   cycle_count out CNT_W   cycles since reset/clear
//   inst_count out  CNT_W   records captured
//   drop_count out  CNT_W   records lost to full FIFO
//   overflow   out  1       sticky: drop_count nonzero
//   halted     out  1       sticky: halt record captured
//   timeout    out  1       sticky: watchdog expired
//   done       out  1       (halted|timeout) & FIFO empty
// BEHAVIOUR
//   Reset (rst_n=0, async) or clear=1: all outputs 0, FIFO empty; clear wins over all other inputs.
//   run = ~halted & ~timeout. cycle_count +1 each cycle while run; frozen otherwise.
//   Capture when ret_valid & run. Kind priority: reg_we&mem_rd->LOAD, reg_we->REG, hlt->HALT,
//     mem_wr->STORE, else NOP. ret_inst ignored except for trace width checks (not stored).
//   Captured record gets out_inum = inst_count pre-increment; inst_count +1 per capture, dropped or not.
//   HALT capture sets halted next edge; further ret_valid ignored. ret_valid with !run: no effect.
//   Watchdog: when TIMEOUT!=0 and cycle_count==TIMEOUT-1 with run, timeout sets next edge;
//     a capture in that same cycle is still recorded.
//   FIFO: FWFT, pointers with extra wrap bit; record visible on out_* one cycle after capture.
//   Pop on out_valid & out_ready. Push when full and no pop in same cycle -> record dropped,
//     drop_count +1, overflow set. Full + simultaneous pop + push: both happen, no drop.
//   Empty + push + out_ready: no bypass; record appears next cycle.
//   out_* hold stable while out_valid & ~out_ready. out_* fields are 0 when out_valid=0.
//   Counters wrap modulo 2^CNT_W silently.
//   done is combinational from halted, timeout and FIFO empty.
// TESTING
//   Reset then 3 retires (reg_we r3=0x0012, store [0x0040]=0xBEEF, nop) with out_ready=1 ->
//     records kind 1/3/0, inum 0/1/2, values 0x0012/0xBEEF/0; inst_count=3.
//   Load r5<-0x00AA from 0x0100, hlt 2 cycles later -> LOAD record addr 0x0100, HALT inum 1;
//     halted=1, cycle_count frozen, later ret_valid ignored, done after drain.
//   out_ready=0, ret_valid every cycle for DEPTH+3 cycles -> DEPTH records kept, drop_count=3,
//     overflow=1, drained order inum 0..DEPTH-1.
//   Full FIFO, ret_valid and out_ready same cycle -> no drop, occupancy stays DEPTH.
//   TIMEOUT=20, no hlt -> timeout=1 after 20 cycles, cycle_count=20, capture stops.
//   Assert rst_n low mid-stream with 5 records queued -> out_valid=0, all counters/flags 0
//     immediately (async); clear=1 yields same state on next edge.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// Retirement-trace recorder: classifies each retired instruction, numbers it and queues the
// record in a first-word-fall-through FIFO, alongside cycle/instruction/drop counters.
module retire_trace_buffer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              ret_valid,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic [DATA_W-1:0] ret_inst,
    input  logic              reg_we,
    input  logic [REG_W-1:0]  reg_dst,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  out_inum,
    output logic [DATA_W-1:0] out_pc,
    output logic [REG_W-1:0]  out_reg,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_value,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              timeout,
    output logic              done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [2:0] KIND_NOP   = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_HALT  = 3'd4;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [2:0]        mem_kind  [DEPTH];
    logic [CNT_W-1:0]  mem_inum  [DEPTH];
    logic [DATA_W-1:0] mem_pc    [DEPTH];
    logic [REG_W-1:0]  mem_reg   [DEPTH];
    logic [DATA_W-1:0] mem_addr_q[DEPTH];
    logic [DATA_W-1:0] mem_value [DEPTH];

    logic              run, capture, empty, full, pop, push, drop, wdog_hit;
    logic [2:0]        cap_kind;
    logic [REG_W-1:0]  cap_reg;
    logic [DATA_W-1:0] cap_addr, cap_value;
    logic [AW-1:0]     rd_idx;

    // The instruction word is accepted for trace-width compatibility but never stored.
    logic unused_inst;
    assign unused_inst = ^ret_inst;

    assign run      = ~halted & ~timeout;
    assign capture  = ret_valid & run;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & out_ready;
    assign push     = capture & (~full | pop);
    assign drop     = capture & full & ~pop;
    assign wdog_hit = (TIMEOUT != 0) && run && (cycle_count == WDOG_LAST);
    assign rd_idx   = rd_ptr[AW-1:0];

    always_comb begin
        cap_kind  = KIND_NOP;
        cap_reg   = '0;
        cap_addr  = '0;
        cap_value = '0;
        if (reg_we && mem_rd) begin
            cap_kind  = KIND_LOAD;
            cap_reg   = reg_dst;
            cap_addr  = mem_addr;
            cap_value = reg_data;
        end else if (reg_we) begin
            cap_kind  = KIND_REG;
            cap_reg   = reg_dst;
            cap_value = reg_data;
        end else if (hlt) begin
            cap_kind  = KIND_HALT;
        end else if (mem_wr) begin
            cap_kind  = KIND_STORE;
            cap_addr  = mem_addr;
            cap_value = mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (run)      cycle_count <= cycle_count + CNT_W'(1);
            if (capture)  inst_count  <= inst_count + CNT_W'(1);
            if (drop) begin
                drop_count <= drop_count + CNT_W'(1);
                overflow   <= 1'b1;
            end
            if (capture && cap_kind == KIND_HALT) halted <= 1'b1;
            if (wdog_hit) timeout <= 1'b1;
            if (push)     wr_ptr  <= wr_ptr + (AW+1)'(1);
            if (pop)      rd_ptr  <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_kind  [wr_ptr[AW-1:0]] <= cap_kind;
            mem_inum  [wr_ptr[AW-1:0]] <= inst_count;
            mem_pc    [wr_ptr[AW-1:0]] <= ret_pc;
            mem_reg   [wr_ptr[AW-1:0]] <= cap_reg;
            mem_addr_q[wr_ptr[AW-1:0]] <= cap_addr;
            mem_value [wr_ptr[AW-1:0]] <= cap_value;
        end
    end

    always_comb begin
        out_valid = ~empty;
        out_kind  = '0;
        out_inum  = '0;
        out_pc    = '0;
        out_reg   = '0;
        out_addr  = '0;
        out_value = '0;
        if (!empty) begin
            out_kind  = mem_kind[rd_idx];
            out_inum  = mem_inum[rd_idx];
            out_pc    = mem_pc[rd_idx];
            out_reg   = mem_reg[rd_idx];
            out_addr  = mem_addr_q[rd_idx];
            out_value = mem_value[rd_idx];
        end
    end

    assign done = (halted | timeout) & empty;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a record table for classification, plus sequences
// for halt, overflow, full push/pop, no-bypass, async reset, clear and watchdog.
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, clear, ret_valid, reg_we, mem_rd, mem_wr, hlt, out_ready;
    logic [15:0] ret_pc, ret_inst, reg_data, mem_addr, mem_data;
    logic [3:0]  reg_dst;
    logic        out_valid, overflow, halted, timeout, done;
    logic [2:0]  out_kind;
    logic [31:0] out_inum, cycle_count, inst_count, drop_count;
    logic [15:0] out_pc, out_addr, out_value;
    logic [3:0]  out_reg;

    logic        to_clear, to_ret_valid;
    logic        to_out_valid, to_overflow, to_halted, to_timeout, to_done;
    logic [2:0]  to_out_kind;
    logic [31:0] to_out_inum, to_cycle_count, to_inst_count, to_drop_count;
    logic [15:0] to_out_pc, to_out_addr, to_out_value;
    logic [3:0]  to_out_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_trace_buffer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_inst(ret_inst), .reg_we(reg_we), .reg_dst(reg_dst), .reg_data(reg_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum),
        .out_pc(out_pc), .out_reg(out_reg), .out_addr(out_addr), .out_value(out_value),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .overflow(overflow), .halted(halted), .timeout(timeout), .done(done)
    );

    retire_trace_buffer #(.TIMEOUT(20)) dut_to (
        .clk(clk), .rst_n(rst_n), .clear(to_clear), .ret_valid(to_ret_valid), .ret_pc(16'h0),
        .ret_inst(16'h0), .reg_we(1'b1), .reg_dst(4'h1), .reg_data(16'h0001), .mem_rd(1'b0),
        .mem_wr(1'b0), .mem_addr(16'h0), .mem_data(16'h0), .hlt(1'b0),
        .out_valid(to_out_valid), .out_ready(1'b1), .out_kind(to_out_kind),
        .out_inum(to_out_inum), .out_pc(to_out_pc), .out_reg(to_out_reg),
        .out_addr(to_out_addr), .out_value(to_out_value), .cycle_count(to_cycle_count),
        .inst_count(to_inst_count), .drop_count(to_drop_count), .overflow(to_overflow),
        .halted(to_halted), .timeout(to_timeout), .done(to_done)
    );

    typedef struct {
        logic        we, rd, wr, ht;
        logic [15:0] pc, rdata, addr, mdata;
        logic [3:0]  dst;
        logic [2:0]  e_kind;
        logic [3:0]  e_reg;
        logic [15:0] e_addr, e_value;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ret_valid = 1'b0; reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; hlt = 1'b0;
        ret_pc = '0; ret_inst = '0; reg_dst = '0; reg_data = '0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        ret_valid = 1'b1; reg_we = v.we; mem_rd = v.rd; mem_wr = v.wr; hlt = v.ht;
        ret_pc = v.pc; ret_inst = 16'hA5A5; reg_dst = v.dst; reg_data = v.rdata;
        mem_addr = v.addr; mem_data = v.mdata;
    endtask

    task automatic drive_reg(input logic [15:0] data);
        idle_inputs();
        ret_valid = 1'b1; reg_we = 1'b1; reg_dst = 4'h2; reg_data = data; ret_pc = data;
    endtask

    initial begin
        // Non-selected fields carry junk to prove they are zeroed in the record.
        vecs[0] = '{we:1, rd:0, wr:0, ht:0, pc:16'h0010, rdata:16'h0012, addr:16'h5555,
                    mdata:16'h7777, dst:4'd3, e_kind:3'd1, e_reg:4'd3, e_addr:16'h0,
                    e_value:16'h0012};
        vecs[1] = '{we:0, rd:0, wr:1, ht:0, pc:16'h0012, rdata:16'h1111, addr:16'h0040,
                    mdata:16'hBEEF, dst:4'd7, e_kind:3'd3, e_reg:4'd0, e_addr:16'h0040,
                    e_value:16'hBEEF};
        vecs[2] = '{we:0, rd:0, wr:0, ht:0, pc:16'h0014, rdata:16'h2222, addr:16'h3333,
                    mdata:16'h4444, dst:4'd9, e_kind:3'd0, e_reg:4'd0, e_addr:16'h0,
                    e_value:16'h0};
        vecs[3] = '{we:1, rd:1, wr:1, ht:0, pc:16'h0016, rdata:16'h00AA, addr:16'h0100,
                    mdata:16'h6666, dst:4'd5, e_kind:3'd2, e_reg:4'd5, e_addr:16'h0100,
                    e_value:16'h00AA};
        vecs[4] = '{we:1, rd:0, wr:0, ht:1, pc:16'h0018, rdata:16'h0ABC, addr:16'h0200,
                    mdata:16'h0, dst:4'd1, e_kind:3'd1, e_reg:4'd1, e_addr:16'h0,
                    e_value:16'h0ABC};
        vecs[5] = '{we:0, rd:0, wr:1, ht:1, pc:16'h001A, rdata:16'h0123, addr:16'h0300,
                    mdata:16'h0456, dst:4'd4, e_kind:3'd4, e_reg:4'd0, e_addr:16'h0,
                    e_value:16'h0};

        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; to_clear = 1'b0; to_ret_valid = 1'b0;
        idle_inputs();
        #3;
        check("reset out_valid", out_valid, 0);
        check("reset inst_count", inst_count, 0);
        check("reset cycle_count", cycle_count, 0);
        check("reset done", done, 0);

        // Classification table; the halt record closes the run.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_vec(vecs[i]);
            @(negedge clk);
        end
        idle_inputs();
        check("halt inst_count", inst_count, 6);
        check("halt halted", halted, 1);
        check("halt cycle_count", cycle_count, 6);
        check("halt done pending", done, 0);
        for (int i = 0; i < 3; i++) begin
            drive_reg(16'h0F0F);
            @(negedge clk);
        end
        idle_inputs();
        check("ignored inst_count", inst_count, 6);
        check("frozen cycle_count", cycle_count, 6);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tbl%0d valid", i), out_valid, 1);
            check($sformatf("tbl%0d kind", i), out_kind, vecs[i].e_kind);
            check($sformatf("tbl%0d inum", i), out_inum, i);
            check($sformatf("tbl%0d pc", i), out_pc, vecs[i].pc);
            check($sformatf("tbl%0d reg", i), out_reg, vecs[i].e_reg);
            check($sformatf("tbl%0d addr", i), out_addr, vecs[i].e_addr);
            check($sformatf("tbl%0d value", i), out_value, vecs[i].e_value);
            @(negedge clk);
        end
        check("drained out_valid", out_valid, 0);
        check("drained out_pc zero", out_pc, 0);
        check("drained done", done, 1);
        out_ready = 1'b0;

        // Overflow: DEPTH+3 pushes with no consumer.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear halted", halted, 0);
        check("clear cycle_count", cycle_count, 0);
        check("clear done", done, 0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive_reg(16'(i));
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        check("ovf drop_count", drop_count, 3);
        check("ovf overflow", overflow, 1);
        check("ovf inst_count", inst_count, DEPTH + 3);
        check("ovf head inum", out_inum, 0);
        check("ovf head value", out_value, 0);
        // Full with simultaneous push and pop: no drop.
        drive_reg(16'h0099);
        out_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("fullpp drop_count", drop_count, 3);
        check("fullpp inst_count", inst_count, DEPTH + 4);
        for (int j = 0; j < DEPTH; j++) begin
            check($sformatf("drain%0d valid", j), out_valid, 1);
            check($sformatf("drain%0d inum", j), out_inum, (j < DEPTH - 1) ? j + 1 : DEPTH + 3);
            check($sformatf("drain%0d value", j), out_value,
                  (j < DEPTH - 1) ? j + 1 : 16'h0099);
            @(negedge clk);
        end
        check("drain empty", out_valid, 0);

        // Empty + push + ready: no bypass.
        drive_reg(16'h0055);
        #1;
        check("nobypass same cycle", out_valid, 0);
        @(negedge clk);
        idle_inputs();
        check("nobypass next valid", out_valid, 1);
        check("nobypass next inum", out_inum, DEPTH + 4);
        check("nobypass next value", out_value, 16'h0055);
        @(negedge clk);
        check("nobypass popped", out_valid, 0);
        out_ready = 1'b0;

        // Asynchronous reset mid-stream with 5 records queued.
        for (int i = 0; i < 5; i++) begin
            drive_reg(16'(i + 16'h10));
            @(negedge clk);
        end
        idle_inputs();
        check("prereset valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async inst_count", inst_count, 0);
        check("async cycle_count", cycle_count, 0);
        check("async drop_count", drop_count, 0);
        check("async overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear with 5 records queued and halted set; clear beats a concurrent retire.
        for (int i = 0; i < 4; i++) begin
            drive_reg(16'(i + 16'h20));
            @(negedge clk);
        end
        idle_inputs();
        ret_valid = 1'b1; hlt = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("preclear halted", halted, 1);
        check("preclear inst_count", inst_count, 5);
        clear = 1'b1;
        drive_reg(16'h0777);
        @(negedge clk);
        clear = 1'b0;
        idle_inputs();
        check("sclr out_valid", out_valid, 0);
        check("sclr halted", halted, 0);
        check("sclr inst_count", inst_count, 0);
        check("sclr cycle_count", cycle_count, 0);
        check("sclr done", done, 0);

        // Watchdog on the TIMEOUT=20 instance.
        to_clear = 1'b1;
        @(negedge clk);
        to_clear = 1'b0;
        to_ret_valid = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 19) begin
                check("wdog k19 timeout", to_timeout, 0);
                check("wdog k19 cycle_count", to_cycle_count, 19);
            end
        end
        to_ret_valid = 1'b0;
        check("wdog timeout", to_timeout, 1);
        check("wdog cycle_count", to_cycle_count, 20);
        check("wdog inst_count", to_inst_count, 20);
        check("wdog halted", to_halted, 0);
        check("wdog drop_count", to_drop_count, 0);
        check("wdog out_valid", to_out_valid, 0);
        check("wdog done", to_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
